// File: rtl/atconv_dilated.sv
// Dilated 3x3 shift-kernel convolution with replicate padding, bias and ReLU (layer 0),
// followed by optional 2x2 max-pooling with round-up to integer (layer 1).
`timescale 1ns/1ps
module atconv_dilated #(
  parameter int IMG_W   = 64,
  parameter int DIL     = 2,
  parameter int DW      = 13,
  parameter int FRAC    = 4,
  parameter int BIAS    = -12,
  parameter int POOL_EN = 1,
  localparam int LW     = $clog2(IMG_W),
  localparam int AW     = 2 * LW
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ready,
  output logic                 busy,
  output logic [AW-1:0]        iaddr,
  input  logic signed [DW-1:0] idata,
  output logic                 cwr,
  output logic [AW-1:0]        caddr_wr,
  output logic signed [DW-1:0] cdata_wr,
  output logic                 crd,
  output logic [AW-1:0]        caddr_rd,
  input  logic signed [DW-1:0] cdata_rd,
  output logic                 csel
);

  localparam int ACW = DW + 4;
  localparam int CW  = LW + 2;
  localparam int PW  = LW - 1;
  localparam int OW  = 2 * PW;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CONV_RD = 3'd1;
  localparam logic [2:0] S_CONV_WB = 3'd2;
  localparam logic [2:0] S_POOL_RD = 3'd3;
  localparam logic [2:0] S_POOL_WB = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic signed [CW-1:0]  DIL_C    = CW'(DIL);
  localparam logic signed [CW-1:0]  MAX_C    = CW'(IMG_W - 1);
  localparam logic signed [ACW-1:0] BIAS_A   = ACW'(BIAS);
  localparam logic signed [ACW-1:0] MAX_ACC  = ACW'((2 ** (DW - 1)) - 1);
  localparam logic signed [DW:0]    MAX_P1   = {2'b00, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0]  MAX_PIX  = {1'b0, {(DW-1){1'b1}}};
  localparam logic [AW-1:0]         PIX_ONE  = AW'(1);
  localparam logic [AW-1:0]         PIX_LAST = AW'(IMG_W * IMG_W - 1);
  localparam logic [OW-1:0]         OUT_ONE  = OW'(1);
  localparam logic [OW-1:0]         OUT_LAST = OW'((IMG_W / 2) * (IMG_W / 2) - 1);

  logic [2:0]            r_state;
  logic [AW-1:0]         r_pix;
  logic [3:0]            r_tap;
  logic signed [ACW-1:0] r_acc;
  logic [OW-1:0]         r_pout;
  logic [2:0]            r_pcnt;
  logic signed [DW-1:0]  r_max;
  logic signed [ACW-1:0] w_acc_nxt;
  logic signed [DW-1:0]  w_max_nxt;

  function automatic logic [LW-1:0] clamp_coord(input logic [LW-1:0] base, input logic [1:0] off);
    logic signed [CW-1:0] v;
    begin
      case (off)
        2'd0:    v = $signed({2'b00, base}) - DIL_C;
        2'd2:    v = $signed({2'b00, base}) + DIL_C;
        default: v = $signed({2'b00, base});
      endcase
      if (v[CW-1])
        clamp_coord = {LW{1'b0}};
      else if (v > MAX_C)
        clamp_coord = {LW{1'b1}};
      else
        clamp_coord = v[LW-1:0];
    end
  endfunction

  function automatic logic [AW-1:0] tap_addr(input logic [AW-1:0] pix, input logic [3:0] k);
    logic [1:0] ro;
    logic [1:0] co;
    begin
      case (k)
        4'd0:    begin ro = 2'd0; co = 2'd0; end
        4'd1:    begin ro = 2'd0; co = 2'd1; end
        4'd2:    begin ro = 2'd0; co = 2'd2; end
        4'd3:    begin ro = 2'd1; co = 2'd0; end
        4'd5:    begin ro = 2'd1; co = 2'd2; end
        4'd6:    begin ro = 2'd2; co = 2'd0; end
        4'd7:    begin ro = 2'd2; co = 2'd1; end
        4'd8:    begin ro = 2'd2; co = 2'd2; end
        default: begin ro = 2'd1; co = 2'd1; end
      endcase
      tap_addr = {clamp_coord(pix[AW-1:LW], ro), clamp_coord(pix[LW-1:0], co)};
    end
  endfunction

  // Weights are powers of two, so every non-centre tap is a floor shift then subtract.
  function automatic logic signed [ACW-1:0] tap_term(input logic signed [DW-1:0] d, input logic [3:0] k);
    logic signed [ACW-1:0] ext;
    begin
      ext = $signed({{4{d[DW-1]}}, d});
      case (k)
        4'd4:                   tap_term = ext;
        4'd1, 4'd7:             tap_term = -(ext >>> 3);
        4'd3, 4'd5:             tap_term = -(ext >>> 2);
        4'd0, 4'd2, 4'd6, 4'd8: tap_term = -(ext >>> 4);
        default:                tap_term = {ACW{1'b0}};
      endcase
    end
  endfunction

  function automatic logic signed [DW-1:0] relu_sat(input logic signed [ACW-1:0] acc);
    logic signed [ACW-1:0] s;
    begin
      s = acc + BIAS_A;
      if (s[ACW-1])
        relu_sat = {DW{1'b0}};
      else if (s > MAX_ACC)
        relu_sat = MAX_PIX;
      else
        relu_sat = s[DW-1:0];
    end
  endfunction

  function automatic logic signed [DW-1:0] pool_round(input logic signed [DW-1:0] m);
    logic signed [DW:0] t;
    begin
      t = {m[DW-1], m[DW-1:FRAC], {FRAC{1'b0}}} + {{(DW-FRAC){1'b0}}, 1'b1, {FRAC{1'b0}}};
      if (m[FRAC-1:0] == {FRAC{1'b0}})
        pool_round = m;
      else if (t > MAX_P1)
        pool_round = MAX_PIX;
      else
        pool_round = t[DW-1:0];
    end
  endfunction

  // Block (i,j) reads layer-0 rows 2i,2i+1 and columns 2j,2j+1 in raster order.
  function automatic logic [AW-1:0] pool_addr(input logic [OW-1:0] o, input logic [1:0] p);
    pool_addr = {o[OW-1:PW], p[1], o[PW-1:0], p[0]};
  endfunction

  // Next accumulator and running pool maximum from the data returned this cycle.
  always_comb begin
    w_acc_nxt = r_acc + tap_term(idata, r_tap - 4'd1);
    if (r_pcnt == 3'd1)
      w_max_nxt = cdata_rd;
    else if (cdata_rd > r_max)
      w_max_nxt = cdata_rd;
    else
      w_max_nxt = r_max;
  end

  // Sequencer: owns the FSM, counters and every registered output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_pix    <= {AW{1'b0}};
      r_tap    <= 4'd0;
      r_acc    <= {ACW{1'b0}};
      r_pout   <= {OW{1'b0}};
      r_pcnt   <= 3'd0;
      r_max    <= {DW{1'b0}};
      busy     <= 1'b0;
      iaddr    <= {AW{1'b0}};
      cwr      <= 1'b0;
      caddr_wr <= {AW{1'b0}};
      cdata_wr <= {DW{1'b0}};
      crd      <= 1'b0;
      caddr_rd <= {AW{1'b0}};
      csel     <= 1'b0;
    end else begin
      cwr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ready) begin
            r_state <= S_CONV_RD;
            busy    <= 1'b1;
            r_pix   <= {AW{1'b0}};
            r_tap   <= 4'd0;
            r_acc   <= {ACW{1'b0}};
            iaddr   <= tap_addr({AW{1'b0}}, 4'd0);
          end
        end
        S_CONV_RD: begin
          if (r_tap != 4'd0) r_acc <= w_acc_nxt;
          if (r_tap < 4'd8) iaddr <= tap_addr(r_pix, r_tap + 4'd1);
          if (r_tap == 4'd9) begin
            r_state  <= S_CONV_WB;
            cwr      <= 1'b1;
            csel     <= 1'b0;
            caddr_wr <= r_pix;
            cdata_wr <= relu_sat(w_acc_nxt);
          end else begin
            r_tap <= r_tap + 4'd1;
          end
        end
        S_CONV_WB: begin
          r_tap <= 4'd0;
          r_acc <= {ACW{1'b0}};
          if (r_pix != PIX_LAST) begin
            r_state <= S_CONV_RD;
            r_pix   <= r_pix + PIX_ONE;
            iaddr   <= tap_addr(r_pix + PIX_ONE, 4'd0);
          end else if (POOL_EN != 0) begin
            r_state  <= S_POOL_RD;
            r_pout   <= {OW{1'b0}};
            r_pcnt   <= 3'd0;
            crd      <= 1'b1;
            caddr_rd <= pool_addr({OW{1'b0}}, 2'd0);
          end else begin
            r_state <= S_DONE;
            busy    <= 1'b0;
          end
        end
        S_POOL_RD: begin
          if (r_pcnt != 3'd0) r_max <= w_max_nxt;
          if (r_pcnt < 3'd3) begin
            crd      <= 1'b1;
            caddr_rd <= pool_addr(r_pout, r_pcnt[1:0] + 2'd1);
          end else begin
            crd <= 1'b0;
          end
          if (r_pcnt == 3'd4) begin
            r_state  <= S_POOL_WB;
            cwr      <= 1'b1;
            csel     <= 1'b1;
            caddr_wr <= {2'b00, r_pout};
            cdata_wr <= pool_round(w_max_nxt);
          end else begin
            r_pcnt <= r_pcnt + 3'd1;
          end
        end
        S_POOL_WB: begin
          csel   <= 1'b0;
          r_pcnt <= 3'd0;
          if (r_pout != OUT_LAST) begin
            r_state  <= S_POOL_RD;
            r_pout   <= r_pout + OUT_ONE;
            crd      <= 1'b1;
            caddr_rd <= pool_addr(r_pout + OUT_ONE, 2'd0);
          end else begin
            r_state <= S_DONE;
            busy    <= 1'b0;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          crd     <= 1'b0;
          csel    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_atconv_dilated.sv
// Directed bench: a 16x16 pooled instance and an 8x8 conv-only instance, each backed by
// a behavioural ROM/RAM, with hand-computed expectations and a small reference model.
`timescale 1ns/1ps
module tb_atconv_dilated;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, ready_a, ready_b, clr;

  logic busy_a, cwr_a, crd_a, csel_a;
  logic [7:0] iaddr_a, caddr_wr_a, caddr_rd_a;
  logic signed [12:0] idata_a, cdata_wr_a, cdata_rd_a;

  logic busy_b, cwr_b, crd_b, csel_b;
  logic [5:0] iaddr_b, caddr_wr_b, caddr_rd_b;
  logic signed [12:0] idata_b, cdata_wr_b, cdata_rd_b;

  logic signed [12:0] img_a [256];
  logic signed [12:0] l0_a  [256];
  logic signed [12:0] l1_a  [64];
  logic signed [12:0] img_b [64];
  logic signed [12:0] l0_b  [64];

  int mimg [256];
  int ml0  [256];
  int ml1  [64];

  int checks = 0;
  int errors = 0;
  int busy_cnt_a, busy_cnt_b, both_a, both_b, csel1_b, hiaddr_a, strobe_rst;

  atconv_dilated #(.IMG_W(16), .DIL(2), .DW(13), .FRAC(4), .BIAS(-12), .POOL_EN(1)) dut (
    .clk(clk), .reset_n(reset_n), .ready(ready_a), .busy(busy_a),
    .iaddr(iaddr_a), .idata(idata_a), .cwr(cwr_a), .caddr_wr(caddr_wr_a),
    .cdata_wr(cdata_wr_a), .crd(crd_a), .caddr_rd(caddr_rd_a),
    .cdata_rd(cdata_rd_a), .csel(csel_a)
  );

  atconv_dilated #(.IMG_W(8), .DIL(1), .DW(13), .FRAC(4), .BIAS(-12), .POOL_EN(0)) dut8 (
    .clk(clk), .reset_n(reset_n), .ready(ready_b), .busy(busy_b),
    .iaddr(iaddr_b), .idata(idata_b), .cwr(cwr_b), .caddr_wr(caddr_wr_b),
    .cdata_wr(cdata_wr_b), .crd(crd_b), .caddr_rd(caddr_rd_b),
    .cdata_rd(cdata_rd_b), .csel(csel_b)
  );

  // ROM and RAM read ports, one-cycle latency.
  always @(posedge clk) begin
    idata_a <= img_a[iaddr_a];
    idata_b <= img_b[iaddr_b];
    if (crd_a) cdata_rd_a <= l0_a[caddr_rd_a];
    if (crd_b) cdata_rd_b <= l0_b[caddr_rd_b];
  end

  // RAM write ports plus protocol monitors; clr refills the banks with a sentinel.
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) l0_a[i] <= 13'sh0AAA;
      for (int i = 0; i < 64; i++) l1_a[i] <= 13'sh0AAA;
      for (int i = 0; i < 64; i++) l0_b[i] <= 13'sh0AAA;
      busy_cnt_a <= 0; busy_cnt_b <= 0; both_a <= 0; both_b <= 0;
      csel1_b <= 0; hiaddr_a <= 0; strobe_rst <= 0;
    end else begin
      if (busy_a) busy_cnt_a <= busy_cnt_a + 1;
      if (busy_b) busy_cnt_b <= busy_cnt_b + 1;
      if (cwr_a && csel_a) begin
        l1_a[caddr_wr_a[5:0]] <= cdata_wr_a;
        if (caddr_wr_a[7:6] != 2'b00) hiaddr_a <= hiaddr_a + 1;
      end else if (cwr_a) begin
        l0_a[caddr_wr_a] <= cdata_wr_a;
      end
      if (cwr_b) l0_b[caddr_wr_b] <= cdata_wr_b;
      if (cwr_b && csel_b) csel1_b <= csel1_b + 1;
      if (cwr_a && crd_a) both_a <= both_a + 1;
      if (cwr_b && crd_b) both_b <= both_b + 1;
      if (!reset_n && (cwr_a || crd_a)) strobe_rst <= strobe_rst + 1;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
  endtask

  task automatic run_a(input int ready_again);
    int cnt;
    @(negedge clk) ready_a = 1'b1;
    @(negedge clk) ready_a = 1'b0;
    chk("a_busy_rise", int'(busy_a), 1);
    cnt = 0;
    while (busy_a && cnt < 5000) begin
      @(negedge clk);
      cnt++;
      ready_a = (cnt == ready_again) ? 1'b1 : 1'b0;
    end
    ready_a = 1'b0;
    chk("a_busy_fall", int'(busy_a), 0);
  endtask

  task automatic run_b();
    int cnt;
    @(negedge clk) ready_b = 1'b1;
    @(negedge clk) ready_b = 1'b0;
    cnt = 0;
    while (busy_b && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    chk("b_busy_fall", int'(busy_b), 0);
  endtask

  // Reference model: clamped taps, floor-shift weights, bias, ReLU, saturation, round-up pool.
  task automatic build_model(input int n, input int dil);
    int acc, d, rr, cc, v, m;
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        acc = 0;
        for (int k = 0; k < 9; k++) begin
          rr = r + (k / 3 - 1) * dil;
          cc = c + (k % 3 - 1) * dil;
          if (rr < 0) rr = 0;
          if (rr > n - 1) rr = n - 1;
          if (cc < 0) cc = 0;
          if (cc > n - 1) cc = n - 1;
          d = mimg[rr * n + cc];
          if (k == 4) acc = acc + d;
          else if (k == 1 || k == 7) acc = acc - (d >>> 3);
          else if (k == 3 || k == 5) acc = acc - (d >>> 2);
          else acc = acc - (d >>> 4);
        end
        v = acc - 12;
        if (v < 0) v = 0;
        if (v > 4095) v = 4095;
        ml0[r * n + c] = v;
      end
    end
    for (int i = 0; i < n / 2; i++) begin
      for (int j = 0; j < n / 2; j++) begin
        m = ml0[2 * i * n + 2 * j];
        if (ml0[2 * i * n + 2 * j + 1] > m) m = ml0[2 * i * n + 2 * j + 1];
        if (ml0[(2 * i + 1) * n + 2 * j] > m) m = ml0[(2 * i + 1) * n + 2 * j];
        if (ml0[(2 * i + 1) * n + 2 * j + 1] > m) m = ml0[(2 * i + 1) * n + 2 * j + 1];
        if ((m & 15) != 0) m = (m & ~15) + 16;
        if (m > 4095) m = 4095;
        ml1[i * (n / 2) + j] = m;
      end
    end
  endtask

  task automatic cmp_model_a(input string tag);
    int mis0, mis1;
    mis0 = 0;
    mis1 = 0;
    for (int i = 0; i < 256; i++) if (int'(l0_a[i]) !== ml0[i]) mis0++;
    for (int i = 0; i < 64; i++) if (int'(l1_a[i]) !== ml1[i]) mis1++;
    chk({tag, "_l0_model_mismatches"}, mis0, 0);
    chk({tag, "_l1_model_mismatches"}, mis1, 0);
  endtask

  initial begin
    int mis, e;
    reset_n = 1'b1; ready_a = 1'b0; ready_b = 1'b0; clr = 1'b0;
    for (int i = 0; i < 256; i++) img_a[i] = 13'sd0;
    for (int i = 0; i < 64; i++) img_b[i] = 13'sd0;
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs_a", int'(|{busy_a, cwr_a, crd_a, csel_a, iaddr_a, caddr_wr_a, cdata_wr_a, caddr_rd_a}), 0);
    chk("reset_outputs_b", int'(|{busy_b, cwr_b, crd_b, csel_b, iaddr_b, caddr_wr_b, cdata_wr_b, caddr_rd_b}), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Impulse plus three isolated pixels that set up the pool-rounding blocks.
    img_a[10 * 16 + 10] = 13'sd16;
    img_a[2 * 16 + 2]   = 13'sd31;
    img_a[4 * 16 + 8]   = 13'sd60;
    img_a[4 * 16 + 9]   = 13'sd28;
    clear_mem();
    run_a(0);
    chk("impulse_busy_cycles", busy_cnt_a, 3200);
    chk("impulse_l0_10_10", int'(l0_a[10 * 16 + 10]), 4);
    chk("impulse_l0_10_12", int'(l0_a[10 * 16 + 12]), 0);
    chk("impulse_l0_12_10", int'(l0_a[12 * 16 + 10]), 0);
    chk("impulse_l0_8_8", int'(l0_a[8 * 16 + 8]), 0);
    chk("pool_src_l0_2_2", int'(l0_a[2 * 16 + 2]), 32'h13);
    chk("pool_src_l0_4_8", int'(l0_a[4 * 16 + 8]), 32'h30);
    chk("pool_src_l0_4_9", int'(l0_a[4 * 16 + 9]), 32'h10);
    mis = 0;
    for (int i = 0; i < 256; i++) begin
      e = 0;
      if (i == 10 * 16 + 10) e = 4;
      if (i == 2 * 16 + 2) e = 32'h13;
      if (i == 4 * 16 + 8) e = 32'h30;
      if (i == 4 * 16 + 9) e = 32'h10;
      if (int'(l0_a[i]) !== e) mis++;
    end
    chk("impulse_l0_other_nonzero", mis, 0);
    chk("pool_round_up_l1_1_1", int'(l1_a[1 * 8 + 1]), 32'h20);
    chk("pool_exact_l1_2_4", int'(l1_a[2 * 8 + 4]), 32'h30);
    chk("pool_impulse_l1_5_5", int'(l1_a[5 * 8 + 5]), 32'h10);
    mis = 0;
    for (int i = 0; i < 64; i++) begin
      e = 0;
      if (i == 9) e = 32'h20;
      if (i == 20) e = 32'h30;
      if (i == 45) e = 32'h10;
      if (int'(l1_a[i]) !== e) mis++;
    end
    chk("impulse_l1_other_nonzero", mis, 0);
    chk("l1_upper_addr_bits", hiaddr_a, 0);
    chk("a_cwr_crd_overlap", both_a, 0);

    // Constant image: kernel sum is zero, bias drives every pixel to zero incl. clamped corners.
    for (int i = 0; i < 256; i++) img_a[i] = 13'sd160;
    clear_mem();
    run_a(0);
    chk("const_l0_0_0", int'(l0_a[0]), 0);
    chk("const_l0_15_15", int'(l0_a[255]), 0);
    mis = 0;
    for (int i = 0; i < 256; i++) if (l0_a[i] !== 13'sd0) mis++;
    chk("const_l0_nonzero", mis, 0);
    mis = 0;
    for (int i = 0; i < 64; i++) if (l1_a[i] !== 13'sd0) mis++;
    chk("const_l1_nonzero", mis, 0);

    // Saturation: max centre, min-valued taps around it.
    for (int i = 0; i < 256; i++) img_a[i] = 13'sd0;
    img_a[5 * 16 + 5] = 13'sd4095;
    for (int dr = -2; dr <= 2; dr += 2)
      for (int dc = -2; dc <= 2; dc += 2)
        if (dr != 0 || dc != 0) img_a[(5 + dr) * 16 + (5 + dc)] = -13'sd4096;
    for (int i = 0; i < 256; i++) mimg[i] = int'(img_a[i]);
    build_model(16, 2);
    clear_mem();
    run_a(0);
    chk("sat_l0_5_5", int'(l0_a[5 * 16 + 5]), 4095);
    chk("sat_l1_2_2", int'(l1_a[2 * 8 + 2]), 4095);
    cmp_model_a("sat");

    // Abort mid-run with reset, then restart with a stray ready pulse during the run.
    for (int i = 0; i < 256; i++) img_a[i] = 13'($urandom_range(0, 8191));
    for (int i = 0; i < 256; i++) mimg[i] = int'(img_a[i]);
    build_model(16, 2);
    clear_mem();
    @(negedge clk) ready_a = 1'b1;
    @(negedge clk) ready_a = 1'b0;
    repeat (2000) @(negedge clk);
    chk("busy_before_abort", int'(busy_a), 1);
    reset_n = 1'b0;
    #1;
    chk("abort_outputs_zero", int'(|{busy_a, cwr_a, crd_a, csel_a, iaddr_a, caddr_wr_a, cdata_wr_a, caddr_rd_a}), 0);
    repeat (5) @(negedge clk);
    chk("strobes_during_reset", strobe_rst, 0);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_until_ready", int'(busy_a), 0);
    clear_mem();
    run_a(100);
    chk("restart_busy_cycles", busy_cnt_a, 3200);
    cmp_model_a("restart");

    // Small geometry, unit dilation, no pooling.
    for (int i = 0; i < 64; i++) img_b[i] = 13'($urandom_range(0, 8191));
    for (int i = 0; i < 64; i++) mimg[i] = int'(img_b[i]);
    build_model(8, 1);
    clear_mem();
    run_b();
    chk("sweep_busy_cycles", busy_cnt_b, 704);
    mis = 0;
    for (int i = 0; i < 64; i++) if (int'(l0_b[i]) !== ml0[i]) mis++;
    chk("sweep_l0_model_mismatches", mis, 0);
    chk("sweep_csel1_writes", csel1_b, 0);
    chk("b_cwr_crd_overlap", both_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
